// File: rtl/bcd_to_bin.sv
// bcd_to_bin: sequential sign + 3-digit BCD to N-bit two's-complement converter
// using reverse double dabble (shift right, subtract 3 from any digit >= 8).
// Optional build macro BCD_TO_BIN_SATURATE_EN: saturate the result on overflow
// instead of wrapping to the low N bits.
module bcd_to_bin #(
  parameter int unsigned N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         sign,
  input  logic [3:0]   hundreds,
  input  logic [3:0]   tens,
  input  logic [3:0]   ones,
  output logic [N-1:0] binary,
  output logic         busy,
  output logic         data_ready,
  output logic         invalid,
  output logic         overflow
);

  localparam int unsigned BCD_W  = 12;
  localparam int unsigned MAG_W  = 10;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned CMP_W  = 17;
  localparam int unsigned ITERS  = 10;

  localparam logic [CMP_W-1:0] LIM_POS = CMP_W'((64'd1 << (N - 1)) - 64'd1);
  localparam logic [CMP_W-1:0] LIM_NEG = CMP_W'(64'd1 << (N - 1));
  localparam logic [N-1:0]     SAT_POS = {1'b0, {(N - 1){1'b1}}};
  localparam logic [N-1:0]     SAT_NEG = {1'b1, {(N - 1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WORK   = 2'd1,
    FINISH = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic [MAG_W-1:0]   mag_q, mag_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               sign_q, sign_d;
  logic [N-1:0]       binary_d;
  logic               busy_d, ready_d, invalid_d, overflow_d;

  logic [BCD_W+MAG_W-1:0] shifted;
  logic [BCD_W-1:0]       bcd_adj;
  logic [MAG_W-1:0]       mag_shift;
  logic [N-1:0]           mag_n;
  logic [N-1:0]           wrap_val;
  logic                   mag_over;
  logic                   digit_bad;

  // One reverse double dabble step: shift right, then correct each digit >= 8
  always_comb begin
    shifted   = {bcd_q, mag_q} >> 1;
    bcd_adj   = shifted[BCD_W+MAG_W-1:MAG_W];
    mag_shift = shifted[MAG_W-1:0];
    for (int i = 0; i < 3; i++) begin
      if (bcd_adj[4*i +: 4] >= 4'd8) begin
        bcd_adj[4*i +: 4] = bcd_adj[4*i +: 4] - 4'd3;
      end
    end
  end

  // Result formatting: range check against the signed limit and N-bit negation
  always_comb begin
    mag_n     = N'(mag_q);
    wrap_val  = sign_q ? (~mag_n + N'(1)) : mag_n;
    mag_over  = sign_q ? (CMP_W'(mag_q) > LIM_NEG) : (CMP_W'(mag_q) > LIM_POS);
    digit_bad = (hundreds > 4'd9) || (tens > 4'd9) || (ones > 4'd9);
  end

  // Next-state and next-output logic
  always_comb begin
    state_d    = state_q;
    bcd_d      = bcd_q;
    mag_d      = mag_q;
    cnt_d      = cnt_q;
    sign_d     = sign_q;
    binary_d   = binary;
    invalid_d  = invalid;
    overflow_d = overflow;
    busy_d     = (state_q == WORK) || (state_q == FINISH);
    ready_d    = (state_q == DONE);

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          bcd_d      = {hundreds, tens, ones};
          sign_d     = sign;
          mag_d      = '0;
          cnt_d      = CNT_W'(ITERS);
          ready_d    = 1'b0;
          invalid_d  = 1'b0;
          overflow_d = 1'b0;
          if (digit_bad) begin
            state_d   = DONE;
            invalid_d = 1'b1;
            binary_d  = '0;
          end else begin
            state_d = WORK;
          end
        end
      end
      WORK: begin
        bcd_d = bcd_adj;
        mag_d = mag_shift;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = FINISH;
        end
      end
      FINISH: begin
        state_d    = DONE;
        overflow_d = mag_over;
        if (mag_over) begin
`ifdef BCD_TO_BIN_SATURATE_EN
          binary_d = sign_q ? SAT_NEG : SAT_POS;
`else
          binary_d = wrap_val;
`endif
        end else begin
          binary_d = wrap_val;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, datapath and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      bcd_q      <= '0;
      mag_q      <= '0;
      cnt_q      <= '0;
      sign_q     <= 1'b0;
      binary     <= '0;
      busy       <= 1'b0;
      data_ready <= 1'b0;
      invalid    <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      state_q    <= state_d;
      bcd_q      <= bcd_d;
      mag_q      <= mag_d;
      cnt_q      <= cnt_d;
      sign_q     <= sign_d;
      binary     <= binary_d;
      busy       <= busy_d;
      data_ready <= ready_d;
      invalid    <= invalid_d;
      overflow   <= overflow_d;
    end
  end

endmodule

// File: tb/tb_bcd_to_bin.sv
// tb_bcd_to_bin: table-driven scoreboard bench for bcd_to_bin at N=8 and N=16.
module tb_bcd_to_bin;

`ifdef BCD_TO_BIN_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  typedef struct {
    logic        sgn;
    logic [3:0]  h;
    logic [3:0]  t;
    logic [3:0]  o;
    logic [7:0]  e8;
    logic        o8;
    logic [15:0] e16;
    logic        o16;
    logic        inv;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        sign = 1'b0;
  logic [3:0]  hundreds = '0;
  logic [3:0]  tens = '0;
  logic [3:0]  ones = '0;
  logic [7:0]  binary8;
  logic [15:0] binary16;
  logic        busy8, ready8, inv8, ovf8;
  logic        busy16, ready16, inv16, ovf16;

  int n_cmp = 0;
  int n_err = 0;
  vec_t sb[$];
  vec_t vecs[12];

  always #5 clk = ~clk;

  bcd_to_bin #(.N(8)) dut8 (
    .clk(clk), .rst(rst), .start(start), .sign(sign),
    .hundreds(hundreds), .tens(tens), .ones(ones),
    .binary(binary8), .busy(busy8), .data_ready(ready8),
    .invalid(inv8), .overflow(ovf8)
  );

  bcd_to_bin #(.N(16)) dut16 (
    .clk(clk), .rst(rst), .start(start), .sign(sign),
    .hundreds(hundreds), .tens(tens), .ones(ones),
    .binary(binary16), .busy(busy16), .data_ready(ready16),
    .invalid(inv16), .overflow(ovf16)
  );

  function automatic vec_t mk(input logic s, input logic [3:0] h, input logic [3:0] t,
                              input logic [3:0] o, input logic [7:0] e8, input logic o8,
                              input logic [15:0] e16, input logic o16, input logic inv);
    vec_t v;
    v.sgn = s; v.h = h; v.t = t; v.o = o;
    v.e8 = e8; v.o8 = o8; v.e16 = e16; v.o16 = o16; v.inv = inv;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one conversion, optionally re-pulse start mid-WORK, then score the result
  task automatic convert(input vec_t v, input int restart_at);
    int   busy_cnt;
    int   lat;
    bit   got;
    vec_t e;
    @(negedge clk);
    sign = v.sgn; hundreds = v.h; tens = v.t; ones = v.o; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    sb.push_back(v);
    check("ready_clr_on_accept", 32'(ready8), 32'd0);
    busy_cnt = 0; lat = 0; got = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      if (k == restart_at) begin
        sign = ~v.sgn; hundreds = 4'd4; tens = 4'd5; ones = 4'd6; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      if (busy8) busy_cnt++;
      if (ready8) begin
        lat = k; got = 1'b1;
        break;
      end
    end
    start = 1'b0;
    if (!got) begin
      n_cmp++; n_err++;
      $display("FAIL timeout: data_ready never rose for %0h%0h%0h", v.h, v.t, v.o);
      void'(sb.pop_front());
    end else if (sb.size() == 0) begin
      n_cmp++; n_err++;
      $display("FAIL scoreboard: result with empty queue");
    end else begin
      e = sb.pop_front();
      check("latency", 32'(lat), e.inv ? 32'd1 : 32'd12);
      check("busy_cycles", 32'(busy_cnt), e.inv ? 32'd0 : 32'd11);
      check("binary8", 32'(binary8), 32'(e.e8));
      check("invalid8", 32'(inv8), 32'(e.inv));
      check("overflow8", 32'(ovf8), 32'(e.o8));
      check("ready16", 32'(ready16), 32'd1);
      check("binary16", 32'(binary16), 32'(e.e16));
      check("invalid16", 32'(inv16), 32'(e.inv));
      check("overflow16", 32'(ovf16), 32'(e.o16));
    end
  endtask

  initial begin
    vecs[0]  = mk(1'b0, 4'd1, 4'd2, 4'd3, 8'h7B, 1'b0, 16'h007B, 1'b0, 1'b0);
    vecs[1]  = mk(1'b1, 4'd1, 4'd2, 4'd8, 8'h80, 1'b0, 16'hFF80, 1'b0, 1'b0);
    vecs[2]  = mk(1'b1, 4'd0, 4'd0, 4'd0, 8'h00, 1'b0, 16'h0000, 1'b0, 1'b0);
    vecs[3]  = mk(1'b0, 4'd1, 4'd2, 4'd8, SAT ? 8'h7F : 8'h80, 1'b1, 16'h0080, 1'b0, 1'b0);
    vecs[4]  = mk(1'b0, 4'd9, 4'd9, 4'd9, SAT ? 8'h7F : 8'hE7, 1'b1, 16'h03E7, 1'b0, 1'b0);
    vecs[5]  = mk(1'b1, 4'd9, 4'd9, 4'd9, SAT ? 8'h80 : 8'h19, 1'b1, 16'hFC19, 1'b0, 1'b0);
    vecs[6]  = mk(1'b0, 4'd1, 4'd2, 4'd7, 8'h7F, 1'b0, 16'h007F, 1'b0, 1'b0);
    vecs[7]  = mk(1'b1, 4'd1, 4'd2, 4'd9, SAT ? 8'h80 : 8'h7F, 1'b1, 16'hFF7F, 1'b0, 1'b0);
    vecs[8]  = mk(1'b0, 4'd1, 4'hA, 4'd3, 8'h00, 1'b0, 16'h0000, 1'b0, 1'b1);
    vecs[9]  = mk(1'b0, 4'd0, 4'd4, 4'd2, 8'h2A, 1'b0, 16'h002A, 1'b0, 1'b0);
    vecs[10] = mk(1'b1, 4'd0, 4'd0, 4'd1, 8'hFF, 1'b0, 16'hFFFF, 1'b0, 1'b0);
    vecs[11] = mk(1'b1, 4'd3, 4'd0, 4'hF, 8'h00, 1'b0, 16'h0000, 1'b0, 1'b1);

    repeat (2) @(posedge clk);
    #1;
    check("rst_binary", 32'(binary8), 32'd0);
    check("rst_busy", 32'(busy8), 32'd0);
    check("rst_ready", 32'(ready8), 32'd0);
    check("rst_flags", {30'd0, inv8, ovf8}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Back-to-back conversions, each started from DONE after the first
    for (int i = 0; i < 12; i++) begin
      convert(vecs[i], 0);
    end

    // Start re-pulsed with other digits during WORK is ignored
    convert(vecs[0], 5);

    // Reset in the middle of WORK aborts to the reset values
    @(negedge clk);
    sign = 1'b0; hundreds = 4'd9; tens = 4'd8; ones = 4'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_busy", 32'(busy8), 32'd0);
    check("midrst_ready", 32'(ready8), 32'd0);
    check("midrst_binary", 32'(binary8), 32'd0);
    check("midrst_binary16", 32'(binary16), 32'd0);

    // Reset together with start: reset wins and nothing starts
    @(negedge clk);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_start_busy", 32'(busy8), 32'd0);
    check("rst_start_ready", 32'(ready8), 32'd0);

    convert(mk(1'b0, 4'd0, 4'd0, 4'd7, 8'h07, 1'b0, 16'h0007, 1'b0, 1'b0), 0);

    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/bcd_to_bin.md
Name: bcd_to_bin

Overview:
- Sequential BCD-to-signed-binary converter using reverse double dabble: shift right one bit per cycle, then subtract 3 from any BCD digit >= 8.
- Takes sign plus three BCD digits (hundreds/tens/ones) and produces an N-bit two's-complement value.
- Flags invalid digits and out-of-range magnitudes.
- Sits on the input side of the display/keypad path, opposite the binary-to-BCD converter, so a number can be entered as digits and used as binary.

Parameters:
- N, 8, output binary width in bits; legal range 2..16.

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  request conversion; sampled only when not busy
- sign  input  1  1 = negative value
- hundreds  input  4  BCD hundreds digit
- tens  input  4  BCD tens digit
- ones  input  4  BCD ones digit
- binary  output  N  signed two's-complement result, held while data_ready
- busy  output  1  high in WORK and FINISH
- data_ready  output  1  high in DONE, level (not a pulse)
- invalid  output  1  a captured digit was > 9; valid while data_ready
- overflow  output  1  magnitude out of N-bit signed range; valid while data_ready

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high; it is evaluated only on the rising edge of clk.
- Reset values: state=IDLE; binary=0, busy=0, data_ready=0, invalid=0, overflow=0; internal registers cleared.
- States:
  - IDLE, WORK, FINISH, DONE.
  - Unused encodings go to IDLE on the next edge.
- Accept:
  - In IDLE or DONE, start=1 at an edge latches sign and the digits into a 12-bit BCD register {h,t,o}.
  - Clears the 10-bit magnitude register, loads the iteration count with 10, and clears data_ready, invalid and overflow.
- Invalid digit:
  - If any latched digit > 9, the next state is DONE, not WORK.
  - Result: binary=0, invalid=1, overflow=0, so data_ready rises 1 cycle after the accept edge.
- WORK (10 cycles), each cycle:
  - Shift {h,t,o,mag} right by 1; the BCD LSB enters mag[9].
  - Then, per digit, if the digit is >= 8, subtract 3 (4-bit, no borrow between digits).
  - Decrement the count. When the count reaches 0, the next state is FINISH.
- FINISH (1 cycle):
  - mag holds 0..999.
  - Limit is 2^(N-1)-1 when sign=0 and 2^(N-1) when sign=1.
  - If mag > limit, overflow=1 and the result follows the optional feature.
  - Otherwise binary = sign ? -mag : mag, truncated to N bits.
  - A sign of -0 gives binary=0, with no flag.
- DONE:
  - Holds outputs with data_ready=1 until the next accepted start, which goes straight into a new conversion (back-to-back allowed).
- Latency: start sampled at edge E0 → data_ready=1 after edge E0+12 (WORK E1..E10, FINISH E11, DONE E12).
- start while busy=1: ignored and not queued. Digit inputs may change freely during a conversion because they are latched at accept.
- Simultaneous rst and start: rst wins and the module goes to IDLE.
- rst mid-conversion: aborts to IDLE with the reset values on the next edge.
- Width rules: for N >= 11, overflow can never assert. All arithmetic is unsigned on mag, with the final negation in N bits.

Optional Feature:
- Macro: BCD_TO_BIN_SATURATE_EN.
- Defined: on overflow, binary saturates to 2^(N-1)-1 (positive) or -2^(N-1) (negative); overflow=1.
- Undefined: on overflow, binary = low N bits of the two's-complement of ±mag (wrap-around); overflow=1.
- The invalid-digit behaviour is identical in both builds.

Test Plan:
- N=8, sign=0, 1/2/3, start pulse → busy for 11 cycles, data_ready after 12 edges, binary=8'h7B, invalid=0, overflow=0.
- N=8, sign=1, 1/2/8 → binary=8'h80 (-128), overflow=0; sign=1, 0/0/0 → binary=8'h00, no flags.
- N=8, sign=0, 1/2/8 → overflow=1; binary=8'h7F with BCD_TO_BIN_SATURATE_EN, 8'h80 without. Also 9/9/9 with N=16 → 16'h03E7, no overflow.
- tens=4'hA, start → data_ready 1 cycle after accept, invalid=1, binary=0, overflow=0.
- start re-pulsed with new digits at cycle 5 of WORK → ignored; result reflects the first digits. A start in DONE with 0/4/2 → new result 8'h2A after 12 cycles.
- rst asserted at cycle 6 of WORK → next edge: busy=0, data_ready=0, binary=0. A following start with 0/0/7 converts normally to 8'h07.
